wb_regfile: RTL and testbench

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_pkg.sv | 26 ++
 rtl/wb_bypass_mux.sv | 47 ++++
 rtl/wb_regfile.sv | 138 +++++++++++++
 tb/tb_wb_regfile.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Purpose: shared defaults, address width helper, element typedef and counter helper for wb_regfile.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_regfile_pkg;

    // Default geometry of the writeback register files.
    localparam int DEF_WIDTH         = 16;
    localparam int DEF_VECTOR_LENGTH = 16;
    localparam int DEF_NREGS         = 16;

    // Register address width at the default geometry.
    localparam int ADDR_W = $clog2(DEF_NREGS);

    // Committed-write counter width and its saturation value.
    localparam int                CNT_W   = 16;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    // One element of a vector register at the default width.
    typedef logic [DEF_WIDTH-1:0] vec_elem_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/wb_bypass_mux.sv
// Purpose: per-read-port forwarding of same-cycle writeback data into the read path.
// Latency: combinational (0 cycles); the caller registers the result.
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   wr_en, wr_vecop, wr_addr, wr_scalar, wr_vector : the writeback being committed this cycle
//   rd_addr                                        : read address of this port
//   mem_scalar, mem_vector                         : stored contents at rd_addr (pre-write)
//   rd_scalar, rd_vector                           : read data with forwarding applied
// Only compiled when WB_BYPASS_EN is defined.
`ifdef WB_BYPASS_EN
module wb_bypass_mux #(
    parameter int WIDTH         = 16,
    parameter int VECTOR_LENGTH = 16,
    parameter int AW            = 4
) (
    input  logic                              wr_en,
    input  logic                              wr_vecop,
    input  logic [AW-1:0]                     wr_addr,
    input  logic [WIDTH-1:0]                  wr_scalar,
    input  logic [VECTOR_LENGTH-1:0][WIDTH-1:0] wr_vector,
    input  logic [AW-1:0]                     rd_addr,
    input  logic [WIDTH-1:0]                  mem_scalar,
    input  logic [VECTOR_LENGTH-1:0][WIDTH-1:0] mem_vector,
    output logic [WIDTH-1:0]                  rd_scalar,
    output logic [VECTOR_LENGTH-1:0][WIDTH-1:0] rd_vector
);

    logic addr_hit;

    assign addr_hit = wr_en && (wr_addr == rd_addr);

    // Forward only into the file the write actually targets; the other
    // file's register with the same index is untouched by this write.
    always_comb begin
        rd_scalar = mem_scalar;
        rd_vector = mem_vector;
        if (addr_hit && wr_vecop) begin
            rd_vector = wr_vector;
        end
        if (addr_hit && !wr_vecop) begin
            rd_scalar = wr_scalar;
        end
    end

endmodule
`endif

// File: rtl/wb_regfile.sv
// Purpose: writeback-side scalar + vector register files with two registered read ports.
// Latency: reads 1 cycle (rd_en -> data/rd_valid next cycle); writes visible next cycle.
// Backpressure: none; one write and one dual-port read accepted every cycle.
//
// Ports:
//   clk, rst                   : single clock, synchronous active-high reset
//   wr_en/wr_addr/wr_vecop     : writeback commit, destination and target file select
//   wr_vector, wr_scalar       : writeback data for the vector / scalar file
//   rd_en, rd_addr_a/b         : read request capturing both ports
//   rd_scalar_a/b, rd_vector_a/b, rd_valid : registered read results
//   wr_count                   : saturating count of committed writes
// Build option: define WB_BYPASS_EN to forward a same-cycle write to a colliding read;
// without it a colliding read returns the pre-write contents.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int VECTOR_LENGTH = DEF_VECTOR_LENGTH,
    parameter int NREGS         = DEF_NREGS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [$clog2(NREGS)-1:0]            wr_addr,
    input  logic                                wr_vecop,
    input  logic [VECTOR_LENGTH-1:0][WIDTH-1:0] wr_vector,
    input  logic [WIDTH-1:0]                    wr_scalar,
    input  logic [$clog2(NREGS)-1:0]            rd_addr_a,
    input  logic [$clog2(NREGS)-1:0]            rd_addr_b,
    input  logic                                rd_en,
    output logic [WIDTH-1:0]                    rd_scalar_a,
    output logic [WIDTH-1:0]                    rd_scalar_b,
    output logic [VECTOR_LENGTH-1:0][WIDTH-1:0] rd_vector_a,
    output logic [VECTOR_LENGTH-1:0][WIDTH-1:0] rd_vector_b,
    output logic                                rd_valid,
    output logic [CNT_W-1:0]                    wr_count
);

    localparam int AW = $clog2(NREGS);

    // Independent scalar and vector storage, same index space.
    logic [WIDTH-1:0]                    scalar_q [NREGS];
    logic [VECTOR_LENGTH-1:0][WIDTH-1:0] vector_q [NREGS];

    // Read data presented to the output registers.
    logic [WIDTH-1:0]                    scalar_a_nxt;
    logic [WIDTH-1:0]                    scalar_b_nxt;
    logic [VECTOR_LENGTH-1:0][WIDTH-1:0] vector_a_nxt;
    logic [VECTOR_LENGTH-1:0][WIDTH-1:0] vector_b_nxt;

`ifdef WB_BYPASS_EN
    wb_bypass_mux #(
        .WIDTH         (WIDTH),
        .VECTOR_LENGTH (VECTOR_LENGTH),
        .AW            (AW)
    ) u_bypass_a (
        .wr_en      (wr_en),
        .wr_vecop   (wr_vecop),
        .wr_addr    (wr_addr),
        .wr_scalar  (wr_scalar),
        .wr_vector  (wr_vector),
        .rd_addr    (rd_addr_a),
        .mem_scalar (scalar_q[rd_addr_a]),
        .mem_vector (vector_q[rd_addr_a]),
        .rd_scalar  (scalar_a_nxt),
        .rd_vector  (vector_a_nxt)
    );

    wb_bypass_mux #(
        .WIDTH         (WIDTH),
        .VECTOR_LENGTH (VECTOR_LENGTH),
        .AW            (AW)
    ) u_bypass_b (
        .wr_en      (wr_en),
        .wr_vecop   (wr_vecop),
        .wr_addr    (wr_addr),
        .wr_scalar  (wr_scalar),
        .wr_vector  (wr_vector),
        .rd_addr    (rd_addr_b),
        .mem_scalar (scalar_q[rd_addr_b]),
        .mem_vector (vector_q[rd_addr_b]),
        .rd_scalar  (scalar_b_nxt),
        .rd_vector  (vector_b_nxt)
    );
`else
    // Storage updates with non-blocking assignments, so sampling it here on a
    // colliding cycle naturally yields the pre-write contents.
    assign scalar_a_nxt = scalar_q[rd_addr_a];
    assign scalar_b_nxt = scalar_q[rd_addr_b];
    assign vector_a_nxt = vector_q[rd_addr_a];
    assign vector_b_nxt = vector_q[rd_addr_b];
`endif

    // Register files: a commit touches exactly one file.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                scalar_q[i] <= '0;
                vector_q[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_vecop) begin
                vector_q[wr_addr] <= wr_vector;
            end else begin
                scalar_q[wr_addr] <= wr_scalar;
            end
        end
    end

    // Read output registers: load on rd_en, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_scalar_a <= '0;
            rd_scalar_b <= '0;
            rd_vector_a <= '0;
            rd_vector_b <= '0;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_scalar_a <= scalar_a_nxt;
                rd_scalar_b <= scalar_b_nxt;
                rd_vector_a <= vector_a_nxt;
                rd_vector_b <= vector_b_nxt;
            end
        end
    end

    // Committed-write counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wr_en) begin
            wr_count <= sat_inc(wr_count);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Purpose: self-checking bench for wb_regfile, directed scenarios plus randomized traffic vs. a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    typedef vec_elem_t [DEF_VECTOR_LENGTH-1:0] vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic        wr_vecop;
    vec_t        wr_vector;
    logic [15:0] wr_scalar;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        rd_en;
    logic [15:0] rd_scalar_a;
    logic [15:0] rd_scalar_b;
    vec_t        rd_vector_a;
    vec_t        rd_vector_b;
    logic        rd_valid;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain arrays plus the expected output values.
    logic [15:0] ms [16];
    vec_t        mv [16];
    int unsigned mcount;
    logic [15:0] exp_sa, exp_sb;
    vec_t        exp_va, exp_vb;
    logic        exp_valid;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_vecop    (wr_vecop),
        .wr_vector   (wr_vector),
        .wr_scalar   (wr_scalar),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_en       (rd_en),
        .rd_scalar_a (rd_scalar_a),
        .rd_scalar_b (rd_scalar_b),
        .rd_vector_a (rd_vector_a),
        .rd_vector_b (rd_vector_b),
        .rd_valid    (rd_valid),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    // Reads sample the register file as it stood before this cycle's write,
    // except that with forwarding enabled a read of the very register being
    // written (in the file being written) sees the new data.
    function automatic logic [15:0] model_scalar(input logic [3:0] a);
        logic [15:0] v;
        v = ms[a];
`ifdef WB_BYPASS_EN
        if (wr_en && !wr_vecop && wr_addr == a) v = wr_scalar;
`endif
        return v;
    endfunction

    function automatic vec_t model_vector(input logic [3:0] a);
        vec_t v;
        v = mv[a];
`ifdef WB_BYPASS_EN
        if (wr_en && wr_vecop && wr_addr == a) v = wr_vector;
`endif
        return v;
    endfunction

    // Advance model and DUT by one clock; outputs are then sampled 1ns after the edge.
    task automatic cycle();
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                ms[i] = '0;
                mv[i] = '0;
            end
            mcount    = 0;
            exp_sa    = '0;
            exp_sb    = '0;
            exp_va    = '0;
            exp_vb    = '0;
            exp_valid = 1'b0;
        end else begin
            if (rd_en) begin
                exp_sa = model_scalar(rd_addr_a);
                exp_sb = model_scalar(rd_addr_b);
                exp_va = model_vector(rd_addr_a);
                exp_vb = model_vector(rd_addr_b);
            end
            exp_valid = rd_en;
            if (wr_en) begin
                if (wr_vecop) mv[wr_addr] = wr_vector;
                else          ms[wr_addr] = wr_scalar;
                if (mcount < 65535) mcount = mcount + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_vecop  = 1'b0;
        wr_vector = '0;
        wr_scalar = '0;
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (rd_valid !== 1'b0 || wr_count !== 16'h0)
            $display("FAIL reset_state: rd_valid=%b wr_count=%h want 0/0000", rd_valid, wr_count);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            rd_en     = 1'b1;
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            cycle();
            n_checks++;
            if (rd_scalar_a !== 16'h0 || rd_scalar_b !== 16'h0 || rd_vector_a !== '0 ||
                rd_vector_b !== '0 || rd_valid !== 1'b1 || wr_count !== 16'h0)
                $display("FAIL reset_read[%0d]: sa=%h sb=%h valid=%b cnt=%h want 0 0 1 0",
                         i, rd_scalar_a, rd_scalar_b, rd_valid, wr_count);
            else n_pass++;
        end
        idle_inputs();
        cycle();
        n_checks++;
        if (rd_valid !== 1'b0)
            $display("FAIL reset_valid_drop: rd_valid=%b want 0", rd_valid);
        else n_pass++;
    endtask

    task automatic test_scalar_write();
        idle_inputs();
        wr_en     = 1'b1;
        wr_vecop  = 1'b0;
        wr_addr   = 4'd3;
        wr_scalar = 16'hBEEF;
        cycle();
        idle_inputs();
        rd_en     = 1'b1;
        rd_addr_a = 4'd3;
        cycle();
        n_checks++;
        if (rd_scalar_a !== 16'hBEEF || rd_vector_a !== '0 || rd_valid !== 1'b1)
            $display("FAIL scalar_write: sa=%h valid=%b want beef/1 (vector_a zero)", rd_scalar_a, rd_valid);
        else n_pass++;
        n_checks++;
        if (wr_count !== 16'd1)
            $display("FAIL scalar_write_count: got %h want 0001", wr_count);
        else n_pass++;
    endtask

    task automatic test_vector_write();
        vec_t v;
        for (int i = 0; i < 16; i++) v[i] = 16'(i) * 16'h0101;
        idle_inputs();
        wr_en     = 1'b1;
        wr_vecop  = 1'b1;
        wr_addr   = 4'd7;
        wr_vector = v;
        wr_scalar = 16'hDEAD;
        cycle();
        idle_inputs();
        rd_en     = 1'b1;
        rd_addr_a = 4'd7;
        rd_addr_b = 4'd7;
        cycle();
        n_checks++;
        if (rd_vector_a !== v || rd_vector_b !== v)
            $display("FAIL vector_write: a=%h b=%h want %h", rd_vector_a, rd_vector_b, v);
        else n_pass++;
        n_checks++;
        if (rd_vector_a[15] !== 16'h0F0F)
            $display("FAIL vector_elem15: got %h want 0f0f", rd_vector_a[15]);
        else n_pass++;
        n_checks++;
        if (rd_scalar_a !== 16'h0 || rd_scalar_b !== 16'h0)
            $display("FAIL vector_scalar_untouched: sa=%h sb=%h want 0000", rd_scalar_a, rd_scalar_b);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [15:0] want;
`ifdef WB_BYPASS_EN
        want = 16'h00AA;
`else
        want = 16'h0001;
`endif
        idle_inputs();
        wr_en = 1'b1; wr_vecop = 1'b0; wr_addr = 4'd5; wr_scalar = 16'h0001;
        cycle();
        wr_scalar = 16'h00AA;
        rd_en = 1'b1; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
        cycle();
        n_checks++;
        if (rd_scalar_a !== want || rd_scalar_b !== want)
            $display("FAIL collision_scalar: a=%h b=%h want %h", rd_scalar_a, rd_scalar_b, want);
        else n_pass++;
        // Vector write to index 5 colliding with a read: scalar side must not forward.
        wr_vecop  = 1'b1;
        wr_vector = {16{16'h5A5A}};
        wr_scalar = 16'h7777;
        cycle();
        n_checks++;
        if (rd_scalar_a !== 16'h00AA)
            $display("FAIL collision_other_file: sa=%h want 00aa", rd_scalar_a);
        else n_pass++;
        n_checks++;
        if (rd_vector_a !== exp_va)
            $display("FAIL collision_vector: got %h want %h", rd_vector_a, exp_va);
        else n_pass++;
        idle_inputs();
        rd_en = 1'b1; rd_addr_a = 4'd5;
        cycle();
        n_checks++;
        if (rd_vector_a !== {16{16'h5A5A}})
            $display("FAIL collision_next_cycle: got %h want 5a5a...", rd_vector_a);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 4'd2; wr_scalar = 16'h5555;
        cycle();
        rst = 1'b1;
        wr_scalar = 16'h1234;
        rd_en = 1'b1; rd_addr_a = 4'd2;
        cycle();
        rst = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || wr_count !== 16'h0 || rd_scalar_a !== 16'h0)
            $display("FAIL reset_mid_outputs: valid=%b cnt=%h sa=%h want 0/0000/0000",
                     rd_valid, wr_count, rd_scalar_a);
        else n_pass++;
        idle_inputs();
        rd_en = 1'b1; rd_addr_a = 4'd2;
        cycle();
        n_checks++;
        if (rd_scalar_a !== 16'h0 || wr_count !== 16'h0)
            $display("FAIL reset_mid_reg2: sa=%h cnt=%h want 0000/0000", rd_scalar_a, wr_count);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wr_en     = ($urandom_range(0, 3) != 0);
            wr_vecop  = $urandom_range(0, 1);
            wr_addr   = 4'($urandom_range(0, 7));
            wr_scalar = 16'($urandom);
            for (int e = 0; e < 16; e++) wr_vector[e] = 16'($urandom);
            rd_en     = ($urandom_range(0, 2) != 0);
            rd_addr_a = 4'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 4) == 0) ? rd_addr_a : 4'($urandom_range(0, 15));
            cycle();
            n_checks++;
            if (rd_scalar_a !== exp_sa || rd_scalar_b !== exp_sb || rd_vector_a !== exp_va ||
                rd_vector_b !== exp_vb || rd_valid !== exp_valid || wr_count !== 16'(mcount))
                $display("FAIL random[%0d]: sa=%h/%h sb=%h/%h valid=%b/%b cnt=%h/%h va_ok=%b vb_ok=%b",
                         c, rd_scalar_a, exp_sa, rd_scalar_b, exp_sb, rd_valid, exp_valid,
                         wr_count, 16'(mcount), rd_vector_a === exp_va, rd_vector_b === exp_vb);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_counter();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            wr_vecop  = i[0];
            wr_addr   = 4'(i);
            wr_scalar = 16'(i);
            cycle();
        end
        n_checks++;
        if (wr_count !== 16'hFFFE)
            $display("FAIL counter_fffe: got %h want fffe", wr_count);
        else n_pass++;
        cycle();
        n_checks++;
        if (wr_count !== 16'hFFFF)
            $display("FAIL counter_ffff: got %h want ffff", wr_count);
        else n_pass++;
        cycle();
        cycle();
        n_checks++;
        if (wr_count !== 16'hFFFF)
            $display("FAIL counter_saturate: got %h want ffff", wr_count);
        else n_pass++;
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr_a = 4'd1; rd_addr_b = 4'd0;
        cycle();
        n_checks++;
        if (rd_vector_a !== exp_va || rd_scalar_b !== exp_sb)
            $display("FAIL counter_data: sb=%h want %h", rd_scalar_b, exp_sb);
        else n_pass++;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_scalar_write();
        test_vector_write();
        test_collision();
        test_reset_mid();
        test_random();
        test_counter();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
